mtx_mul_sched: RTL and testbench

- Controller that shares one 4x4 8-bit matrix-multiply engine between two requesters.
- Arbitrates requests round-robin, then streams the winner's 16 A/B byte pairs into the engine under a load window.
- Waits for the engine's ready window and returns the 16 18-bit products tagged with index and owner.
- Sits between the client blocks and the engine. Engine-side and client-side signals are plain sampled levels; no other handshake exists.

---
 rtl/mtx_pkg.sv | 17 +
 rtl/mtx_mul_sched_if.sv | 36 +++
 rtl/rr_arb2.sv | 20 ++
 rtl/mtx_mul_sched.sv | 144 ++++++++++++++
 tb/tb_mtx_mul_sched.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtx_pkg.sv
// Shared definitions for the matrix-multiply scheduler: controller states and
// operand/product geometry of the 4x4 8-bit engine.
package mtx_pkg;
  localparam int N_ELEM = 16;
  localparam int ELEM_W = 8;
  localparam int PROD_W = 18;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;
endpackage

// File: rtl/mtx_mul_sched_if.sv
// Client- and engine-side signal bundle of the scheduler; master is the
// scheduler, slave is the surrounding clients plus engine.
interface mtx_mul_sched_if;
  import mtx_pkg::*;

  logic [1:0]        req;
  logic [ELEM_W-1:0] m1_0;
  logic [ELEM_W-1:0] m2_0;
  logic [ELEM_W-1:0] m1_1;
  logic [ELEM_W-1:0] m2_1;
  logic [1:0]        gnt;
  logic [1:0]        rd;
  logic              eng_load;
  logic [ELEM_W-1:0] eng_m1;
  logic [ELEM_W-1:0] eng_m2;
  logic [PROD_W-1:0] eng_mp;
  logic              eng_ready;
  logic              res_valid;
  logic [PROD_W-1:0] res_data;
  logic [IDX_W-1:0]  res_idx;
  logic              res_owner;
  logic [1:0]        done;
  logic [1:0]        err;

  modport master (
    input  req, m1_0, m2_0, m1_1, m2_1, eng_mp, eng_ready,
    output gnt, rd, eng_load, eng_m1, eng_m2,
    output res_valid, res_data, res_idx, res_owner, done, err
  );

  modport slave (
    output req, m1_0, m2_0, m1_1, m2_1, eng_mp, eng_ready,
    input  gnt, rd, eng_load, eng_m1, eng_m2,
    input  res_valid, res_data, res_idx, res_owner, done, err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that was not served last. Grant is zero while disabled.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  input  logic       en,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_served ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end
endmodule

// File: rtl/mtx_mul_sched.sv
// Shares one 4x4 matrix-multiply engine between two requesters: round-robin
// grant, 16-cycle operand load, then collection of the 16 engine products.
module mtx_mul_sched #(
  parameter int TIMEOUT = 64,
  parameter int N_ELEM  = mtx_pkg::N_ELEM
) (
  input logic             clk,
  input logic             rst_n,
  mtx_mul_sched_if.master bus
);
  localparam int IDX_W  = mtx_pkg::IDX_W;
  localparam int PROD_W = mtx_pkg::PROD_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  mtx_pkg::state_t   state;
  mtx_pkg::state_t   state_nxt;
  logic [1:0]        gnt_q;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic [IDX_W-1:0]  k_q;
  logic [IDX_W-1:0]  rcnt_q;
  logic [CNT_W-1:0]  wcnt_q;
  logic              last_q;
  logic              capture;
  logic              res_valid_q;
  logic [PROD_W-1:0] res_data_q;
  logic [IDX_W-1:0]  res_idx_q;
  logic              res_owner_q;

  assign arb_en = (state == mtx_pkg::S_IDLE);

  rr_arb2 u_arb (
    .req         (bus.req),
    .last_served (last_q),
    .en          (arb_en),
    .grant       (arb_gnt)
  );

  // Every ready sample in WAIT or DRAIN is a product; the first one is index 0.
  assign capture = bus.eng_ready &&
                   (state == mtx_pkg::S_WAIT || state == mtx_pkg::S_DRAIN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      mtx_pkg::S_IDLE:  if (arb_gnt != 2'b00) state_nxt = mtx_pkg::S_LOAD;
      mtx_pkg::S_LOAD:  if (k_q == LAST_IDX) state_nxt = mtx_pkg::S_WAIT;
      mtx_pkg::S_WAIT: begin
        if (bus.eng_ready)           state_nxt = mtx_pkg::S_DRAIN;
        else if (wcnt_q == LAST_WAIT) state_nxt = mtx_pkg::S_ABORT;
      end
      mtx_pkg::S_DRAIN: begin
        if (!bus.eng_ready)          state_nxt = mtx_pkg::S_ABORT;
        else if (rcnt_q == LAST_IDX) state_nxt = mtx_pkg::S_DONE;
      end
      mtx_pkg::S_DONE:  state_nxt = mtx_pkg::S_IDLE;
      mtx_pkg::S_ABORT: state_nxt = mtx_pkg::S_IDLE;
      default:          state_nxt = mtx_pkg::S_IDLE;
    endcase
  end

  always_comb begin
    bus.eng_load = 1'b0;
    bus.rd       = 2'b00;
    bus.done     = 2'b00;
    bus.err      = 2'b00;
    unique case (state)
      mtx_pkg::S_LOAD: begin
        bus.eng_load = 1'b1;
        bus.rd       = gnt_q;
      end
      mtx_pkg::S_DONE:  bus.done = gnt_q;
      mtx_pkg::S_ABORT: bus.err  = gnt_q;
      default: ;
    endcase
  end

  // Engine operands follow the granted port; nothing is granted means zero.
  always_comb begin
    bus.eng_m1 = '0;
    bus.eng_m2 = '0;
    if (gnt_q[0]) begin
      bus.eng_m1 = bus.m1_0;
      bus.eng_m2 = bus.m2_0;
    end else if (gnt_q[1]) begin
      bus.eng_m1 = bus.m1_1;
      bus.eng_m2 = bus.m2_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= mtx_pkg::S_IDLE;
      gnt_q  <= 2'b00;
      k_q    <= '0;
      wcnt_q <= '0;
      rcnt_q <= '0;
      last_q <= 1'b1;
    end else begin
      state <= state_nxt;
      unique case (state)
        mtx_pkg::S_IDLE: begin
          gnt_q  <= arb_gnt;
          k_q    <= '0;
          wcnt_q <= '0;
          rcnt_q <= '0;
        end
        mtx_pkg::S_LOAD: k_q <= k_q + 1'b1;
        mtx_pkg::S_WAIT: if (!bus.eng_ready) wcnt_q <= wcnt_q + 1'b1;
        mtx_pkg::S_DONE, mtx_pkg::S_ABORT: begin
          gnt_q  <= 2'b00;
          last_q <= gnt_q[1];
        end
        default: ;
      endcase
      if (capture) rcnt_q <= rcnt_q + 1'b1;
    end
  end

  // Result register: one cycle behind the engine sample, product passed unmodified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_owner_q <= 1'b0;
    end else begin
      res_valid_q <= capture;
      if (capture) begin
        res_data_q  <= bus.eng_mp;
        res_idx_q   <= rcnt_q;
        res_owner_q <= gnt_q[1];
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_owner = res_owner_q;
endmodule

// File: tb/tb_mtx_mul_sched.sv
// Bench for mtx_mul_sched: two modelled requesters, a behavioural 4x4 matmul
// engine with configurable ready window, and directed scenario sequence.
module tb_mtx_mul_sched;
  import mtx_pkg::*;

  localparam int TIMEOUT = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mtx_mul_sched_if bus ();

  mtx_mul_sched #(.TIMEOUT(TIMEOUT), .N_ELEM(N_ELEM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0]  a_src [2][16];
  logic [7:0]  b_src [2][16];
  logic [17:0] c_ref [2][16];
  int          kc    [2];
  int          reps  [2];
  int          mode  [2];
  int          ndone [2];
  int          nerr  [2];

  logic [7:0]  ea [16];
  logic [7:0]  eb [16];
  logic [17:0] eprod [16];
  int          ecap, eng_t, lat, n_ready;
  logic        prev_load;

  int          exp_idx, owner, last_owner;
  int          wait_start, last_err_cyc, resv_total;
  logic [17:0] last_res;
  logic [1:0]  gnt_prev;
  int          gorder [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Operand data for requester g plus the reference product C = A x B.
  task automatic gen_data(input int g);
    for (int i = 0; i < 16; i++) begin
      case (mode[g])
        1: begin a_src[g][i] = (i / 4 == i % 4) ? 8'd1 : 8'd0; b_src[g][i] = 8'(i + 1); end
        2: begin a_src[g][i] = 8'hFF; b_src[g][i] = 8'hFF; end
        default: begin a_src[g][i] = 8'($urandom); b_src[g][i] = 8'($urandom); end
      endcase
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int s = 0;
        for (int j = 0; j < 4; j++) s += int'(a_src[g][r*4+j]) * int'(b_src[g][j*4+c]);
        c_ref[g][r*4+c] = 18'(s);
      end
  endtask

  task automatic start(input int g, input int n, input int md);
    mode[g] = md;
    reps[g] = n;
    kc[g]   = 0;
    gen_data(g);
    bus.req[g] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
    if (bus.gnt != 2'b00 && gnt_prev == 2'b00) gorder.push_back(int'(bus.gnt[1]));
    gnt_prev = bus.gnt;
    if (bus.res_valid) begin
      resv_total++;
      last_res = bus.res_data;
      chk("res_owner", 32'(bus.res_owner), owner);
      chk("res_idx", 32'(bus.res_idx), exp_idx);
      chk("res_data", 32'(bus.res_data), 32'(c_ref[owner][exp_idx % 16]));
      exp_idx++;
    end
    for (int g = 0; g < 2; g++) begin
      if (bus.done[g] || bus.err[g]) begin
        if (bus.done[g]) begin
          ndone[g]++;
          chk("done_rd_count", kc[g], 16);
          chk("done_res_count", exp_idx, 16);
        end else begin
          nerr[g]++;
          last_err_cyc = cyc;
        end
        chk("end_owner", g, owner);
        last_owner = g;
        reps[g]--;
        kc[g] = 0;
        if (reps[g] <= 0) bus.req[g] = 1'b0;
        else gen_data(g);
      end
    end
    // Requesters: granted port presents element k on each rd, idle port shows noise.
    for (int g = 0; g < 2; g++) begin
      logic [7:0] v1, v2;
      if (bus.rd[g] && kc[g] < 16) begin
        v1 = a_src[g][kc[g]];
        v2 = b_src[g][kc[g]];
      end else begin
        v1 = 8'($urandom);
        v2 = 8'($urandom);
      end
      if (bus.rd[g]) kc[g]++;
      if (g == 0) begin bus.m1_0 = v1; bus.m2_0 = v2; end
      else        begin bus.m1_1 = v1; bus.m2_1 = v2; end
    end
    #1;
    if (bus.gnt != 2'b00) begin
      chk("eng_m1_mux", 32'(bus.eng_m1), 32'(bus.gnt[1] ? bus.m1_1 : bus.m1_0));
      chk("eng_m2_mux", 32'(bus.eng_m2), 32'(bus.gnt[1] ? bus.m2_1 : bus.m2_0));
    end
    // Engine: latch operands during the load window, then replay products.
    if (bus.eng_load) begin
      if (!prev_load) begin
        ecap    = 0;
        exp_idx = 0;
        owner   = int'(bus.gnt[1]);
      end
      if (ecap < 16) begin ea[ecap] = bus.eng_m1; eb[ecap] = bus.eng_m2; end
      ecap++;
      eng_t = 0;
      bus.eng_ready = 1'b0;
      bus.eng_mp    = 18'($urandom);
    end else begin
      if (prev_load) begin
        wait_start = cyc;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            int s = 0;
            for (int j = 0; j < 4; j++) s += int'(ea[r*4+j]) * int'(eb[j*4+c]);
            eprod[r*4+c] = 18'(s);
          end
      end
      if (ecap >= 16 && eng_t >= lat && eng_t - lat < n_ready) begin
        bus.eng_ready = 1'b1;
        bus.eng_mp    = eprod[eng_t - lat];
      end else begin
        bus.eng_ready = 1'b0;
        bus.eng_mp    = 18'($urandom);
      end
      eng_t++;
    end
    prev_load = bus.eng_load;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((reps[0] > 0 || reps[1] > 0) && n < budget) begin
      tick();
      n++;
    end
    chk("run_budget", 32'(n < budget), 1);
    repeat (3) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_rd"}, 32'(bus.rd), 0);
    chk({tag, "_eng_load"}, 32'(bus.eng_load), 0);
    chk({tag, "_eng_m1"}, 32'(bus.eng_m1), 0);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    chk({tag, "_res_data"}, 32'(bus.res_data), 0);
    chk({tag, "_res_idx"}, 32'(bus.res_idx), 0);
    chk({tag, "_res_owner"}, 32'(bus.res_owner), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  initial begin
    int d0, e0, rv, n;
    bus.req = 2'b00;
    bus.m1_0 = '0; bus.m2_0 = '0; bus.m1_1 = '0; bus.m2_1 = '0;
    bus.eng_ready = 1'b0; bus.eng_mp = '0;
    ecap = 0; eng_t = 0; lat = 0; n_ready = 16; prev_load = 1'b0;
    exp_idx = 0; owner = 0; last_owner = 1; wait_start = 0; last_err_cyc = 0;
    resv_total = 0; last_res = '0; gnt_prev = 2'b00;
    for (int g = 0; g < 2; g++) begin kc[g] = 0; reps[g] = 0; mode[g] = 0; ndone[g] = 0; nerr[g] = 0; end

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Identity x B: products are B itself, 1..16
    lat = 2; n_ready = 16; rv = resv_total;
    start(0, 1, 1);
    run(200);
    chk("ident_done", ndone[0], 1);
    chk("ident_results", resv_total - rv, 16);
    chk("ident_last", 32'(last_res), 16);

    // All 0xFF operands: worst-case product
    lat = 0;
    start(0, 1, 2);
    run(200);
    chk("worst_done", ndone[0], 2);
    chk("worst_res", 32'(last_res), 32'h3F804);

    // Engine never ready: abort after TIMEOUT wait cycles, no results
    n_ready = 0; rv = resv_total; e0 = nerr[0];
    start(0, 1, 0);
    run(300);
    chk("timeout_err", nerr[0] - e0, 1);
    chk("timeout_latency", last_err_cyc - wait_start, TIMEOUT);
    chk("timeout_no_res", resv_total - rv, 0);

    // Ready dropped after 5 products, then a clean retry
    lat = 1; n_ready = 5; e0 = nerr[1];
    start(1, 1, 0);
    run(200);
    chk("drop_err", nerr[1] - e0, 1);
    chk("drop_res_count", exp_idx, 5);
    n_ready = 16; lat = $urandom_range(0, 5); d0 = ndone[1];
    start(1, 1, 0);
    run(200);
    chk("retry_done", ndone[1] - d0, 1);

    // Asynchronous reset in the middle of LOAD (k=7)
    d0 = ndone[0] + ndone[1]; e0 = nerr[0] + nerr[1];
    start(0, 1, 0);
    n = 0;
    while (kc[0] < 8 && n < 200) begin tick(); n++; end
    chk("rst_reach_k7", 32'(n < 200), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    bus.req = 2'b00; reps[0] = 0; kc[0] = 0;
    bus.eng_ready = 1'b0; prev_load = 1'b0; ecap = 0; gnt_prev = 2'b00; last_owner = 1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("midrst_no_done", ndone[0] + ndone[1] - d0, 0);
    chk("midrst_no_err", nerr[0] + nerr[1] - e0, 0);
    d0 = ndone[1];
    gorder.delete();
    start(1, 1, 0);
    run(200);
    chk("post_rst_done", ndone[1] - d0, 1);
    chk("post_rst_grant", gorder.size() > 0 ? gorder[0] : -1, 1);

    // Both requesters held for two transactions each: grants alternate
    gorder.delete();
    n = (last_owner == 1) ? 0 : 1;
    lat = $urandom_range(0, 5);
    start(0, 2, 0);
    start(1, 2, 0);
    run(600);
    chk("rr_grant_count", gorder.size(), 4);
    for (int i = 0; i < 4 && i < gorder.size(); i++)
      chk("rr_grant_order", gorder[i], (n + i) % 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
